// File: rtl/adc_uart_frame_scheduler.sv
// ---------------------------------------------------------------------------
// adc_uart_frame_scheduler
// Command-driven sequencer that owns the shared UART transmitter. A host
// command byte from the UART receiver selects one ADC channel ('1'..'4') or
// all four ('A'). On accept, all four 10-bit samples are snapshotted. Each
// selected channel is sent as a 3-byte frame: tag 'A'+ch, {6'b0,s[9:8]},
// s[7:0]. Each byte goes out through a tx_en/tx_ready handshake.
//
// Ports
//   clk          system clock, rising edge
//   reset_b      synchronous active-low reset
//   rx_data      last received byte
//   rx_ready     receiver data-ready level; its 0->1 edge is a command
//   adc_ch1..4   latest 10-bit sample per channel
//   tx_ready     UART TX idle (high = ready to accept a byte)
//   tx_data      byte offered to the TX (0 while idle)
//   tx_en        TX start strobe, level while offering
//   tx_write_en  TX data write enable, same timing as tx_en
//   busy         high from command accept until the last byte completes
//   cmd_drop     1-cycle pulse: command ignored (busy or unknown code)
//   tx_timeout   1-cycle pulse: TX never accepted a byte, command aborted
//   frames_sent  completed frame counter, wraps silently
// ---------------------------------------------------------------------------
module adc_uart_frame_scheduler #(
   parameter int ACK_TIMEOUT = 4096,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset_b,
   input  logic [7:0]       rx_data,
   input  logic             rx_ready,
   input  logic [9:0]       adc_ch1,
   input  logic [9:0]       adc_ch2,
   input  logic [9:0]       adc_ch3,
   input  logic [9:0]       adc_ch4,
   input  logic             tx_ready,
   output logic [7:0]       tx_data,
   output logic             tx_en,
   output logic             tx_write_en,
   output logic             busy,
   output logic             cmd_drop,
   output logic             tx_timeout,
   output logic [CNT_W-1:0] frames_sent
);

   localparam int TO_W = $clog2(ACK_TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_LOAD      = 3'd1,
      S_OFFER     = 3'd2,
      S_WAIT_ACK  = 3'd3,
      S_WAIT_DONE = 3'd4
   } state_t;

   state_t            state_r, state_s;
   logic              rx_prev_r;
   logic [9:0]        snap_r [0:3];
   logic [1:0]        ch_r, ch_s;
   logic [1:0]        last_ch_r, last_ch_s;
   logic [1:0]        byte_idx_r, byte_idx_s;
   logic [TO_W-1:0]   to_cnt_r, to_cnt_s;
   logic [7:0]        tx_data_r, tx_data_s;
   logic              strobe_r, strobe_s;
   logic              busy_r, busy_s;
   logic              cmd_drop_r, cmd_drop_s;
   logic              tx_timeout_r, tx_timeout_s;
   logic [CNT_W-1:0]  frames_r, frames_s;

   logic              rx_edge_s;
   logic              cmd_valid_s;
   logic [1:0]        cmd_first_s, cmd_last_s;
   logic              finish_s;
   logic              accept_s;
   logic [9:0]        sel_sample_s;
   logic [7:0]        byte_s;

   // Command decode: single channel n -> range n..n, 'A' -> range 1..4
   always_comb begin
      cmd_valid_s = 1'b0;
      cmd_first_s = 2'd0;
      cmd_last_s  = 2'd0;
      case (rx_data)
         8'h31, 8'h32, 8'h33, 8'h34: begin
            cmd_valid_s = 1'b1;
            cmd_first_s = rx_data[1:0] - 2'd1;
            cmd_last_s  = rx_data[1:0] - 2'd1;
         end
         8'h41: begin
            cmd_valid_s = 1'b1;
            cmd_first_s = 2'd0;
            cmd_last_s  = 2'd3;
         end
         default: begin
            cmd_valid_s = 1'b0;
         end
      endcase
   end

   // Byte selector for the current channel / byte index from the snapshot
   always_comb begin
      sel_sample_s = snap_r[ch_r];
      case (byte_idx_r)
         2'd0:    byte_s = 8'h41 + {6'd0, ch_r};
         2'd1:    byte_s = {6'd0, sel_sample_s[9:8]};
         2'd2:    byte_s = sel_sample_s[7:0];
         default: byte_s = 8'h00;
      endcase
   end

   assign rx_edge_s = rx_ready & ~rx_prev_r;
   // Last byte of last frame completing this cycle: busy is about to fall,
   // so a new command arriving now is taken rather than dropped.
   assign finish_s  = (state_r == S_WAIT_DONE) && tx_ready &&
                      (byte_idx_r == 2'd2) && (ch_r == last_ch_r);
   assign accept_s  = rx_edge_s && cmd_valid_s &&
                      ((state_r == S_IDLE) || finish_s);

   // Next-state and next-output logic
   always_comb begin
      state_s      = state_r;
      ch_s         = ch_r;
      last_ch_s    = last_ch_r;
      byte_idx_s   = byte_idx_r;
      to_cnt_s     = to_cnt_r;
      tx_data_s    = tx_data_r;
      strobe_s     = strobe_r;
      busy_s       = busy_r;
      cmd_drop_s   = rx_edge_s && !accept_s;
      tx_timeout_s = 1'b0;
      frames_s     = frames_r;
      case (state_r)
         S_IDLE: begin
            if (accept_s) begin
               state_s    = S_LOAD;
               ch_s       = cmd_first_s;
               last_ch_s  = cmd_last_s;
               byte_idx_s = 2'd0;
               busy_s     = 1'b1;
            end else begin
               tx_data_s  = 8'h00;
               strobe_s   = 1'b0;
               busy_s     = 1'b0;
            end
         end
         S_LOAD: begin
            if (tx_ready) begin
               state_s   = S_OFFER;
               tx_data_s = byte_s;
               to_cnt_s  = {TO_W{1'b0}};
            end else begin
               state_s   = S_LOAD;
            end
         end
         S_OFFER: begin
            state_s  = S_WAIT_ACK;
            strobe_s = 1'b1;
            to_cnt_s = to_cnt_r + {{(TO_W-1){1'b0}}, 1'b1};
         end
         S_WAIT_ACK: begin
            if (!tx_ready) begin
               state_s  = S_WAIT_DONE;
               strobe_s = 1'b0;
            end else if (to_cnt_r == TO_W'(ACK_TIMEOUT - 1)) begin
               state_s      = S_IDLE;
               strobe_s     = 1'b0;
               tx_timeout_s = 1'b1;
               busy_s       = 1'b0;
               tx_data_s    = 8'h00;
            end else begin
               to_cnt_s = to_cnt_r + {{(TO_W-1){1'b0}}, 1'b1};
            end
         end
         S_WAIT_DONE: begin
            if (tx_ready) begin
               if (byte_idx_r == 2'd2) begin
                  frames_s = frames_r + {{(CNT_W-1){1'b0}}, 1'b1};
                  if (ch_r != last_ch_r) begin
                     state_s    = S_LOAD;
                     ch_s       = ch_r + 2'd1;
                     byte_idx_s = 2'd0;
                  end else if (accept_s) begin
                     state_s    = S_LOAD;
                     ch_s       = cmd_first_s;
                     last_ch_s  = cmd_last_s;
                     byte_idx_s = 2'd0;
                  end else begin
                     state_s    = S_IDLE;
                     busy_s     = 1'b0;
                     tx_data_s  = 8'h00;
                  end
               end else begin
                  state_s    = S_LOAD;
                  byte_idx_s = byte_idx_r + 2'd1;
               end
            end else begin
               state_s = S_WAIT_DONE;
            end
         end
         default: begin
            state_s  = S_IDLE;
            strobe_s = 1'b0;
            busy_s   = 1'b0;
         end
      endcase
   end

   // State, snapshot and registered outputs
   always_ff @(posedge clk) begin
      if (!reset_b) begin
         state_r      <= S_IDLE;
         rx_prev_r    <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            snap_r[i] <= 10'd0;
         end
         ch_r         <= 2'd0;
         last_ch_r    <= 2'd0;
         byte_idx_r   <= 2'd0;
         to_cnt_r     <= {TO_W{1'b0}};
         tx_data_r    <= 8'h00;
         strobe_r     <= 1'b0;
         busy_r       <= 1'b0;
         cmd_drop_r   <= 1'b0;
         tx_timeout_r <= 1'b0;
         frames_r     <= {CNT_W{1'b0}};
      end else begin
         state_r      <= state_s;
         rx_prev_r    <= rx_ready;
         if (accept_s) begin
            snap_r[0] <= adc_ch1;
            snap_r[1] <= adc_ch2;
            snap_r[2] <= adc_ch3;
            snap_r[3] <= adc_ch4;
         end
         ch_r         <= ch_s;
         last_ch_r    <= last_ch_s;
         byte_idx_r   <= byte_idx_s;
         to_cnt_r     <= to_cnt_s;
         tx_data_r    <= tx_data_s;
         strobe_r     <= strobe_s;
         busy_r       <= busy_s;
         cmd_drop_r   <= cmd_drop_s;
         tx_timeout_r <= tx_timeout_s;
         frames_r     <= frames_s;
      end
   end

   assign tx_data     = tx_data_r;
   assign tx_en       = strobe_r;
   assign tx_write_en = strobe_r;
   assign busy        = busy_r;
   assign cmd_drop    = cmd_drop_r;
   assign tx_timeout  = tx_timeout_r;
   assign frames_sent = frames_r;

endmodule

// File: tb/tb_adc_uart_frame_scheduler.sv
// ---------------------------------------------------------------------------
// tb_adc_uart_frame_scheduler
// Directed bench for adc_uart_frame_scheduler with a small UART TX model that
// captures every accepted byte. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_adc_uart_frame_scheduler;

   logic        clk = 1'b0;
   logic        reset_b = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_ready = 1'b0;
   logic [9:0]  adc_ch1 = 10'd0, adc_ch2 = 10'd0, adc_ch3 = 10'd0, adc_ch4 = 10'd0;
   logic        tx_ready = 1'b1;
   logic [7:0]  tx_data;
   logic        tx_en, tx_write_en, busy, cmd_drop, tx_timeout;
   logic [15:0] frames_sent;

   int          checks = 0;
   int          errors = 0;
   logic        tx_auto = 1'b1;
   logic [7:0]  cap [$];

   adc_uart_frame_scheduler #(.ACK_TIMEOUT(16), .CNT_W(16)) dut (
      .clk(clk), .reset_b(reset_b), .rx_data(rx_data), .rx_ready(rx_ready),
      .adc_ch1(adc_ch1), .adc_ch2(adc_ch2), .adc_ch3(adc_ch3), .adc_ch4(adc_ch4),
      .tx_ready(tx_ready), .tx_data(tx_data), .tx_en(tx_en),
      .tx_write_en(tx_write_en), .busy(busy), .cmd_drop(cmd_drop),
      .tx_timeout(tx_timeout), .frames_sent(frames_sent)
   );

   always #5 clk = ~clk;

   // UART TX model: accepts an offered byte, stays busy two cycles
   initial begin
      forever begin
         @(negedge clk);
         if (tx_auto && tx_en && tx_write_en && tx_ready) begin
            cap.push_back(tx_data);
            tx_ready = 1'b0;
            repeat (2) @(negedge clk);
            tx_ready = 1'b1;
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_b = 1'b0;
      repeat (2) @(negedge clk);
      reset_b = 1'b1;
      @(negedge clk);
   endtask

   // rx_ready rises at a negedge and falls one cycle later
   task automatic send_cmd(input logic [7:0] b);
      @(negedge clk);
      rx_data  = b;
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("idle_reached", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int en_k, to_k, gap;

      // Reset state
      do_reset();
      chk("rst_tx_data", tx_data, 32'h0);
      chk("rst_tx_en", tx_en, 32'h0);
      chk("rst_tx_write_en", tx_write_en, 32'h0);
      chk("rst_busy", busy, 32'h0);
      chk("rst_cmd_drop", cmd_drop, 32'h0);
      chk("rst_tx_timeout", tx_timeout, 32'h0);
      chk("rst_frames", frames_sent, 32'h0);

      // 1: single channel 2, with latency check (tx_en after 3rd posedge)
      adc_ch2 = 10'h2A5;
      cap.delete();
      @(negedge clk);
      rx_data = 8'h32;
      rx_ready = 1'b1;
      @(negedge clk);
      chk("t1_busy_after_accept", busy, 32'h1);
      chk("t1_no_drop", cmd_drop, 32'h0);
      rx_ready = 1'b0;
      @(negedge clk);
      chk("t1_tx_en_early", tx_en, 32'h0);
      @(negedge clk);
      chk("t1_tx_en_latency3", tx_en, 32'h1);
      chk("t1_first_byte_bus", tx_data, 32'h42);
      wait_idle();
      chk("t1_nbytes", cap.size(), 32'd3);
      chk("t1_b0", cap[0], 32'h42);
      chk("t1_b1", cap[1], 32'h02);
      chk("t1_b2", cap[2], 32'hA5);
      chk("t1_frames", frames_sent, 32'd1);
      chk("t1_tx_data_idle", tx_data, 32'h0);

      // 2: all four channels
      do_reset();
      adc_ch1 = 10'h001; adc_ch2 = 10'h3FF; adc_ch3 = 10'h200; adc_ch4 = 10'h0FF;
      cap.delete();
      send_cmd(8'h41);
      wait_idle();
      chk("t2_nbytes", cap.size(), 32'd12);
      chk("t2_b0", cap[0], 32'h41);  chk("t2_b1", cap[1], 32'h00);
      chk("t2_b2", cap[2], 32'h01);  chk("t2_b3", cap[3], 32'h42);
      chk("t2_b4", cap[4], 32'h03);  chk("t2_b5", cap[5], 32'hFF);
      chk("t2_b6", cap[6], 32'h43);  chk("t2_b7", cap[7], 32'h02);
      chk("t2_b8", cap[8], 32'h00);  chk("t2_b9", cap[9], 32'h44);
      chk("t2_b10", cap[10], 32'h00); chk("t2_b11", cap[11], 32'hFF);
      chk("t2_frames", frames_sent, 32'd4);

      // 3: unknown code, then command while busy
      do_reset();
      cap.delete();
      @(negedge clk);
      rx_data = 8'h35;
      rx_ready = 1'b1;
      @(negedge clk);
      chk("t3_drop_pulse", cmd_drop, 32'h1);
      chk("t3_not_busy", busy, 32'h0);
      rx_ready = 1'b0;
      @(negedge clk);
      chk("t3_drop_one_cycle", cmd_drop, 32'h0);
      gap = 0;
      repeat (6) begin
         @(negedge clk);
         if (tx_en) gap++;
      end
      chk("t3_no_tx_en", gap, 32'd0);
      adc_ch1 = 10'h155;
      send_cmd(8'h31);
      repeat (3) @(negedge clk);
      adc_ch1 = 10'h0AA;
      @(negedge clk);
      rx_data = 8'h31;
      rx_ready = 1'b1;
      @(negedge clk);
      chk("t3_busy_drop", cmd_drop, 32'h1);
      rx_ready = 1'b0;
      wait_idle();
      chk("t3_nbytes", cap.size(), 32'd3);
      chk("t3_b0", cap[0], 32'h41);
      chk("t3_b1", cap[1], 32'h01);
      chk("t3_b2", cap[2], 32'h55);
      chk("t3_frames", frames_sent, 32'd1);

      // 4: snapshot coherence
      do_reset();
      cap.delete();
      adc_ch3 = 10'h1C3;
      send_cmd(8'h33);
      adc_ch3 = 10'h03C;
      wait_idle();
      chk("t4_nbytes", cap.size(), 32'd3);
      chk("t4_b0", cap[0], 32'h43);
      chk("t4_b1", cap[1], 32'h01);
      chk("t4_b2", cap[2], 32'hC3);

      // 5: TX never acknowledges -> timeout 16 cycles after OFFER entry
      do_reset();
      tx_auto = 1'b0;
      tx_ready = 1'b1;
      en_k = 0; to_k = 0; gap = 0;
      @(negedge clk);
      rx_data = 8'h31;
      rx_ready = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (k == 1) rx_ready = 1'b0;
         if (tx_en && en_k == 0) en_k = k;
         if (en_k != 0 && !tx_timeout && !tx_en) gap++;
         if (tx_timeout) begin
            to_k = k;
            break;
         end
      end
      chk("t5_tx_en_k", en_k, 32'd3);
      chk("t5_timeout_k", to_k, 32'd18);
      chk("t5_strobe_held", gap, 32'd0);
      chk("t5_tx_en_off", tx_en, 32'h0);
      chk("t5_busy_off", busy, 32'h0);
      @(negedge clk);
      chk("t5_timeout_pulse", tx_timeout, 32'h0);
      chk("t5_frames", frames_sent, 32'd0);
      tx_auto = 1'b1;

      // 6: reset during byte1
      do_reset();
      cap.delete();
      adc_ch4 = 10'h2F0;
      send_cmd(8'h34);
      for (int k = 0; k < 200 && cap.size() < 2; k++) @(negedge clk);
      chk("t6_reached_byte1", cap.size(), 32'd2);
      reset_b = 1'b0;
      @(negedge clk);
      chk("t6_rst_tx_en", tx_en, 32'h0);
      chk("t6_rst_busy", busy, 32'h0);
      chk("t6_rst_tx_data", tx_data, 32'h0);
      chk("t6_rst_frames", frames_sent, 32'h0);
      repeat (3) @(negedge clk);
      reset_b = 1'b1;
      repeat (3) @(negedge clk);
      cap.delete();
      send_cmd(8'h34);
      wait_idle();
      chk("t6_nbytes", cap.size(), 32'd3);
      chk("t6_b0", cap[0], 32'h44);
      chk("t6_b1", cap[1], 32'h02);
      chk("t6_b2", cap[2], 32'hF0);
      chk("t6_frames", frames_sent, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
